// File: rtl/pipe_scroller_pkg.sv
// Playfield geometry, column type, run-state enum and the gap decoder shared by
// the scroller, its interface and anything that reads the obstacle grid.
package pipe_pkg;

   localparam int ROWS  = 16;
   localparam int COLS  = 16;
   localparam int GAP   = 4;
   localparam int COL_W = $clog2(COLS);

   typedef logic [ROWS-1:0] col_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // A fresh pipe column: lit everywhere except a GAP-row hole whose top row is
   // twice the pattern, pushed up so the hole never runs off the bottom edge.
   function automatic col_t gap_column(input logic [2:0] pattern);
      int   top;
      col_t col;
      top = 2 * int'(pattern);
      if (top > ROWS - GAP) begin
         top = ROWS - GAP;
      end
      for (int i = 0; i < ROWS; i++) begin
         col[i] = (i < top) || (i >= top + GAP);
      end
      return col;
   endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Control inputs, step pulses and the combinational grid read port of the scroller.
// slave is the scroller side; master is the game logic / display side.
interface pipe_scroller_if;
   import pipe_pkg::*;

   logic             enable;
   logic             clear;
   logic [2:0]       pattern;
   logic             pattern_take;
   logic             step;
   logic             pipe_passed;
   logic [COL_W-1:0] rd_col;
   col_t             rd_data;
   state_t           state;

   modport slave (
      input  enable, clear, pattern, rd_col,
      output pattern_take, step, pipe_passed, rd_data, state
   );

   modport master (
      output enable, clear, pattern, rd_col,
      input  pattern_take, step, pipe_passed, rd_data, state
   );

endinterface

// File: rtl/pipe_tick_gen.sv
// Scroll-step timer: counts 0..period-1 while run is high and pulses step on the last count.
// Latency: step is combinational from the count; the counter freezes when run is low.
// No backpressure; clear zeroes the count and masks the pulse in the same cycle.
module pipe_tick_gen #(
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          clear,
   input  logic [TW-1:0] period,
   output logic          step
);

   logic [TW-1:0] tick_q;
   logic [TW-1:0] tick_d;
   logic          last;

   // >= keeps the counter wrapping even if the period shrinks below the count.
   assign last = (tick_q >= period - TW'(1));
   assign step = run && !clear && last;

   always_comb begin
      tick_d = tick_q;
      if (clear) begin
         tick_d = '0;
      end else if (run) begin
         tick_d = last ? '0 : tick_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_q <= '0;
      end else begin
         tick_q <= tick_d;
      end
   end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe playfield: shifts the grid left one column per step and inserts a pipe every SPACING steps.
// Latency: pulses are combinational in the step cycle; the new grid reads back after that edge.
// No backpressure; enable low freezes everything. PIPE_SCROLLER_SPEEDUP_EN shortens the step period as pipes accumulate.
module pipe_scroller
   import pipe_pkg::*;
#(
   parameter int SPACING  = 4,
   parameter int TICK_DIV = 8,
   parameter int BIRD_COL = 2
) (
   input  logic            clk,
   input  logic            reset,
   pipe_scroller_if.slave  bus
);

   localparam int            SW          = $clog2(SPACING);
   localparam int            TW          = $clog2(TICK_DIV + 1);
   localparam logic [SW-1:0] SPC_RELOAD  = SW'(SPACING - 1);
   localparam logic [TW-1:0] PERIOD_INIT = TW'(TICK_DIV);

   state_t              state_q;
   state_t              state_d;
   col_t [COLS-1:0]     grid_q;
   col_t [COLS-1:0]     grid_d;
   logic [SW-1:0]       spc_q;
   logic [SW-1:0]       spc_d;
   logic [TW-1:0]       period;
   logic                step;
   logic                take;

   pipe_tick_gen #(
      .TW (TW)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .run    (bus.enable),
      .clear  (bus.clear),
      .period (period),
      .step   (step)
   );

   assign take             = step && (spc_q == '0);
   assign bus.step         = step;
   assign bus.pattern_take = take;
   assign bus.pipe_passed  = step && (grid_q[BIRD_COL] != '0);
   assign bus.rd_data      = grid_q[bus.rd_col];
   assign bus.state        = state_q;

   always_comb begin
      state_d = bus.enable ? RUN : IDLE;
      grid_d  = grid_q;
      spc_d   = spc_q;
      if (bus.clear) begin
         grid_d = '0;
         spc_d  = '0;
      end else if (step) begin
         for (int i = 0; i < COLS - 1; i++) begin
            grid_d[i] = grid_q[i+1];
         end
         grid_d[COLS-1] = take ? gap_column(bus.pattern) : col_t'(0);
         spc_d          = take ? SPC_RELOAD : spc_q - SW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grid_q  <= '0;
         spc_q   <= '0;
      end else begin
         state_q <= state_d;
         grid_q  <= grid_d;
         spc_q   <= spc_d;
      end
   end

`ifdef PIPE_SCROLLER_SPEEDUP_EN
   localparam int            DEC   = (TICK_DIV / 8 > 1) ? TICK_DIV / 8 : 1;
   localparam logic [TW-1:0] DEC_W = TW'(DEC);
   localparam logic [TW-1:0] FLOOR = TW'(TICK_DIV / 2);

   logic [2:0]    pcnt_q;
   logic [2:0]    pcnt_d;
   logic [TW-1:0] period_q;
   logic [TW-1:0] period_d;

   assign period = period_q;

   // The period only changes on an insertion step, when the tick counter is wrapping to 0.
   always_comb begin
      pcnt_d   = pcnt_q;
      period_d = period_q;
      if (bus.clear) begin
         pcnt_d   = '0;
         period_d = PERIOD_INIT;
      end else if (take) begin
         pcnt_d = pcnt_q + 3'd1;
         if (pcnt_q == 3'd7) begin
            period_d = (period_q - FLOOR >= DEC_W) ? period_q - DEC_W : FLOOR;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt_q   <= '0;
         period_q <= PERIOD_INIT;
      end else begin
         pcnt_q   <= pcnt_d;
         period_q <= period_d;
      end
   end
`else
   assign period = PERIOD_INIT;
`endif

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomised scoreboard bench for pipe_scroller against a step-level playfield model.
module tb_pipe_scroller;
   import pipe_pkg::*;

   localparam int SPACING  = 4;
   localparam int TICK_DIV = 8;
   localparam int BIRD_COL = 2;

   typedef struct packed {
      logic [31:0]       cyc;
      logic              take;
      logic              passed;
      logic [15:0][15:0] grid;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   logic [15:0] m_cols [16];
   int          m_run;
   int          m_steps;
   int          m_ins;
   bit          m_stepped;
   logic [2:0]  pats [4] = '{3'd3, 3'd0, 3'd6, 3'd7};

   pipe_scroller_if bus();

   pipe_scroller #(
      .SPACING  (SPACING),
      .TICK_DIV (TICK_DIV),
      .BIRD_COL (BIRD_COL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] gap_ref(input logic [2:0] p);
      int          top;
      logic [15:0] hole;
      top  = 2 * int'(p);
      if (top > 12) top = 12;
      hole = 16'h000F;
      return ~(hole << top);
   endfunction

   function automatic int period_now();
`ifdef PIPE_SCROLLER_SPEEDUP_EN
      int dec;
      int p;
      dec = (TICK_DIV / 8 > 1) ? TICK_DIV / 8 : 1;
      p   = TICK_DIV - (m_ins / 8) * dec;
      return (p < TICK_DIV / 2) ? TICK_DIV / 2 : p;
`else
      return TICK_DIV;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_cols[i] = 16'h0;
      m_run   = 0;
      m_steps = 0;
      m_ins   = 0;
   endtask

   // Called at posedge+1: applies inputs for this cycle, predicts it, then waits for the edge.
   task automatic cycle(input logic en, input logic clr, input logic [2:0] pat);
      exp_t e;
      bus.enable  = en;
      bus.clear   = clr;
      bus.pattern = pat;
      m_stepped   = 0;
      if (clr) begin
         model_reset();
      end else if (en) begin
         if (m_run + 1 == period_now()) begin
            e.cyc    = 32'(cyc);
            e.take   = (m_steps % SPACING) == 0;
            e.passed = (m_cols[BIRD_COL] != 16'h0);
            for (int i = 0; i < 15; i++) m_cols[i] = m_cols[i+1];
            m_cols[15] = e.take ? gap_ref(pat) : 16'h0;
            for (int i = 0; i < 16; i++) e.grid[i] = m_cols[i];
            m_steps++;
            if (e.take) m_ins++;
            m_run     = 0;
            m_stepped = 1;
            exp_q.push_back(e);
         end else begin
            m_run++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: owns rd_col; scores pulses on steps and sweeps the grid the cycle after.
   initial begin
      logic [15:0][15:0] sg;
      logic [15:0][15:0] pg;
      bit                ds;
      bit                pend;
      exp_t              e;
      bus.rd_col = '0;
      pend       = 0;
      pg         = '0;
      forever begin
         @(negedge clk);
         ds   = pend;
         sg   = pg;
         pend = 0;
         if (reset) begin
            if (bus.step) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_step (cycle %0d): got step=1, expected no step", cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("step_cycle", 32'(cyc), e.cyc);
                  check("pattern_take", 32'(bus.pattern_take), 32'(e.take));
                  check("pipe_passed", 32'(bus.pipe_passed), 32'(e.passed));
                  pend = 1;
                  pg   = e.grid;
               end
            end else begin
               check("take_without_step", 32'(bus.pattern_take), 32'd0);
               check("passed_without_step", 32'(bus.pipe_passed), 32'd0);
            end
         end
         if (ds) begin
            for (int c = 0; c < 16; c++) begin
               bus.rd_col = 4'(c);
               #1;
               check($sformatf("grid_col%0d", c), 32'(bus.rd_data), 32'(sg[c]));
            end
         end
      end
   end

   initial begin
      bus.enable  = 1'b0;
      bus.clear   = 1'b0;
      bus.pattern = 3'd0;
      model_reset();
      #5;
      check("reset_step", 32'(bus.step), 32'd0);
      check("reset_take", 32'(bus.pattern_take), 32'd0);
      check("reset_passed", 32'(bus.pipe_passed), 32'd0);
      check("reset_rd_data", 32'(bus.rd_data), 32'd0);
      check("reset_state", 32'(bus.state), 32'(IDLE));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Fixed pattern sequence 3,0,6,7 across insertions; long enough for the first pass.
      for (int k = 0; k < 170; k++) cycle(1'b1, 1'b0, pats[m_ins % 4]);
      check("state_run", 32'(bus.state), 32'(RUN));

      for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 3'($urandom));
      check("state_idle", 32'(bus.state), 32'(IDLE));

      // Line up a clear with a step cycle.
      for (int k = 0; k < 16 && (m_run + 1 != period_now()); k++) cycle(1'b1, 1'b0, 3'd3);
      cycle(1'b1, 1'b1, 3'd5);
      for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, 3'($urandom));

      for (int k = 0; k < 2000; k++) begin
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0, 3'($urandom));
      end

      for (int k = 0; k < 1300; k++) cycle(1'b1, 1'b0, 3'($urandom));

      // Asynchronous reset between edges, a couple of cycles after a step.
      for (int k = 0; k < 20 && !m_stepped; k++) cycle(1'b1, 1'b0, 3'($urandom));
      cycle(1'b1, 1'b0, 3'($urandom));
      cycle(1'b1, 1'b0, 3'($urandom));
      @(negedge clk);
      #17;
      reset = 1'b0;
      #1;
      check("async_step", 32'(bus.step), 32'd0);
      check("async_take", 32'(bus.pattern_take), 32'd0);
      check("async_passed", 32'(bus.pipe_passed), 32'd0);
      check("async_rd_data", 32'(bus.rd_data), 32'd0);
      check("async_state", 32'(bus.state), 32'(IDLE));
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 40; k++) cycle(1'b1, 1'b0, 3'($urandom));

      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 3'd0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Consumes the 3-bit pseudo-random pattern produced by the game's LFSR and turns it into scrolling pipe columns on the ROWS×COLS LED playfield. Holds the playfield's obstacle grid, scrolls it one column left per game step, inserts a new pipe every SPACING steps with its gap position decoded from the sampled pattern, and flags each pipe that scrolls past the bird. Sits between the LFSR and the display and collision logic.

## Interface
- ROWS, 16, playfield rows; row 0 is the top
- COLS, 16, playfield columns; column COLS-1 is the right edge, where pipes enter
- GAP, 4, gap height in rows
- SPACING, 4, steps between pipe insertions (≥2)
- TICK_DIV, 8, clock cycles per scroll step (≥4)
- BIRD_COL, 2, bird's column (1..COLS-2)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- enable  in  1  run when high; freeze grid and all counters when low
- clear  in  1  synchronous grid clear and counter reload
- pattern  in  3  LFSR output, sampled at pipe insertion
- pattern_take  out  1  one-cycle pulse in the cycle `pattern` is consumed
- step  out  1  one-cycle pulse per scroll step
- pipe_passed  out  1  one-cycle pulse when a pipe leaves BIRD_COL
- rd_col  in  $clog2(COLS)  column select
- rd_data  out  ROWS  combinational read of grid[rd_col]; bit i = row i, 1 = pipe lit

## Operation
- States: IDLE (enable=0, everything frozen), RUN (enable=1). Transitions track `enable` on each clock edge.
- Tick counter counts 0..period-1 in RUN. At period-1 it asserts `step` and wraps to 0. The period is TICK_DIV.
- On each step:
  - grid[i] ← grid[i+1] for i < COLS-1; column 0 is discarded.
  - If the spacing counter is 0: grid[COLS-1] ← pipe column, `pattern_take`=1, spacing counter ← SPACING-1.
  - Otherwise: grid[COLS-1] ← 0, spacing counter decrements.
- Gap decode: gap_top = min(2·pattern, ROWS-GAP). Rows gap_top..gap_top+GAP-1 are 0; all other rows are 1.
- `pipe_passed` = step && (pre-shift grid[BIRD_COL] ≠ 0).
- `clear` zeroes the grid, the tick counter and the spacing counter. The first step after a clear therefore inserts a pipe. If `clear` and a step occur in the same cycle, `clear` wins: no pulses fire.
- Reset: grid=0, tick counter=0, spacing counter=0, state=IDLE, `step`/`pattern_take`/`pipe_passed`=0, pipe counter=0.

## Timing
- `step`, `pattern_take` and `pipe_passed` are combinational from the counter state. They are valid in the cycle before the edge that updates the grid. The new grid is visible on `rd_data` after that edge.
- The first step comes TICK_DIV cycles after `enable` rises from reset.
- Dropping `enable` in a step cycle suppresses that step and its pulses.
- Reset assertion clears all state immediately, with no clock edge required. Deassertion takes effect at the next edge.

## Configuration
- PIPE_SCROLLER_SPEEDUP_EN defined:
  - A pipe counter increments on each insertion.
  - Every 8 insertions, the tick period decreases by max(1, TICK_DIV/8), with a floor of TICK_DIV/2.
  - `clear` restores the period to TICK_DIV.
- Not defined: the period is fixed at TICK_DIV and there is no pipe counter.

## Structure
- Package `pipe_pkg`:
  - ROWS/COLS/GAP defaults
  - typedef col_t (logic [ROWS-1:0])
  - state enum {IDLE, RUN}
  - function gap_column(pattern) returning col_t
- Sub-module `pipe_tick_gen`: the tick counter with a run-time period input. It produces `step`.

## Test plan
- Reset, enable=1, pattern=3: `step` and `pattern_take` pulse at the 8th cycle. After that edge, rd_col=15 → rd_data=16'hFC3F and rd_col=14 → 16'h0000.
- Pattern decode: pattern=0 → 16'hFFF0; pattern=6 → 16'h0FFF (clamped); pattern=7 → 16'h0FFF (clamped).
- Spacing: `pattern_take` fires on steps 1, 5, 9. Column 15 reads 0 after steps 2–4. After step 4, the first pipe is in column 12.
- Pass detection: the pipe inserted at step 1 is in column 2 after step 14. `pipe_passed` pulses exactly on step 15, once.
- Freeze/clear: enable=0 for 20 cycles → no pulses, grid unchanged. `clear` coincident with a step → no pulses, grid all 0, next step inserts a pipe.
- Asynchronous reset mid-run: drop `reset` between edges → all outputs 0 and rd_data=0 immediately. With PIPE_SCROLLER_SPEEDUP_EN, after 8 insertions the step spacing is 7 cycles, reaching a floor of 4.
